// File: rtl/axis_header_arbiter_pkg.sv
// axis_header_arbiter_pkg: shared FSM states and counter widths for the header arbiter.
package axis_header_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, OFFER, WAIT_PKT} state_t;
  localparam int HDR_CNT_WD = 16;
endpackage

// File: rtl/axis_header_arbiter_rr_arbiter.sv
// axis_header_arbiter_rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant plus index.
module axis_header_arbiter_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  int k;
  always_comb begin
    grant = '0;
    idx = '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (en && ~|grant && req[k]) begin
        grant[k] = 1'b1;
        idx = W'(k);
      end
    end
  end
endmodule

// File: rtl/axis_header_arbiter.sv
// axis_header_arbiter: round-robin sharing of one header inserter among NUM_SRC requesters,
// holding the grant until the inserted packet's last output beat or a watchdog timeout.
module axis_header_arbiter
  import axis_header_arbiter_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = $clog2(NUM_SRC),
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              req_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      req_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] req_keep,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  req_cnt,
  output logic [NUM_SRC-1:0]              req_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  input  logic                            mon_valid_out,
  input  logic                            mon_ready_out,
  input  logic                            mon_last_out,
  output logic [SRC_WD-1:0]               grant_id,
  output logic                            busy,
  output logic [HDR_CNT_WD-1:0]           hdr_cnt,
  output logic                            err_timeout,
  input  logic                            err_clr
);
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  state_t state;
  logic [SRC_WD-1:0] rr_ptr, idx, nxt_ptr;
  logic [WD_W-1:0] wd;
  logic beat, fire;
  axis_header_arbiter_rr_arbiter #(.N(NUM_SRC), .W(SRC_WD)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .en(state == IDLE),
    .grant(req_ready),
    .idx(idx)
  );
  assign beat = mon_valid_out && mon_ready_out;
  // a beat in the final watchdog cycle takes precedence over the timeout
  assign fire = state == WAIT_PKT && !beat && wd == WD_W'(TIMEOUT_CYC - 1);
  assign nxt_ptr = grant_id == SRC_WD'(NUM_SRC - 1) ? '0 : grant_id + 1'b1;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid_insert <= 1'b0;
      data_insert <= '0;
      keep_insert <= '0;
      byte_insert_cnt <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
      hdr_cnt <= '0;
      err_timeout <= 1'b0;
      wd <= '0;
    end else begin
      if (fire) err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      case (state)
        IDLE: if (|req_ready) begin
          data_insert <= req_data[int'(idx)*DATA_WD +: DATA_WD];
          keep_insert <= req_keep[int'(idx)*DATA_BYTE_WD +: DATA_BYTE_WD];
          byte_insert_cnt <= req_cnt[int'(idx)*BYTE_CNT_WD +: BYTE_CNT_WD];
          grant_id <= idx;
          valid_insert <= 1'b1;
          state <= OFFER;
        end
        OFFER: if (ready_insert) begin
          valid_insert <= 1'b0;
          hdr_cnt <= hdr_cnt + 1'b1;
          wd <= '0;
          state <= WAIT_PKT;
        end
        WAIT_PKT: if (beat) begin
          wd <= '0;
          if (mon_last_out) begin
            rr_ptr <= nxt_ptr;
            state <= IDLE;
          end
        end else if (fire) begin
          rr_ptr <= nxt_ptr;
          state <= IDLE;
        end else wd <= wd + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_header_arbiter.sv
// tb_axis_header_arbiter: scenario tasks with a header scoreboard and a round-robin reference pointer.
module tb_axis_header_arbiter;
  localparam int N = 4, DW = 32, BW = 4, CW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [N*BW-1:0] req_keep = '0;
  logic [N*CW-1:0] req_cnt = '0;
  logic valid_insert, ready_insert = 1'b0, busy, err_timeout, err_clr = 1'b0;
  logic [DW-1:0] data_insert;
  logic [BW-1:0] keep_insert;
  logic [CW-1:0] byte_insert_cnt;
  logic mon_valid_out = 1'b0, mon_ready_out = 1'b0, mon_last_out = 1'b0;
  logic [1:0] grant_id;
  logic [15:0] hdr_cnt;
  int checks = 0, errors = 0, rr_m = 0, hc_m = 0;
  typedef struct {logic [1:0] src; logic [31:0] d; logic [3:0] k; logic [1:0] c;} hdr_t;
  hdr_t sb[$];
  hdr_t h;

  axis_header_arbiter #(.DATA_WD(DW), .NUM_SRC(N), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep),
    .req_cnt(req_cnt), .req_ready(req_ready), .valid_insert(valid_insert), .data_insert(data_insert),
    .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .mon_valid_out(mon_valid_out), .mon_ready_out(mon_ready_out), .mon_last_out(mon_last_out),
    .grant_id(grant_id), .busy(busy), .hdr_cnt(hdr_cnt), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_limit: got still running, want finished");
    $fatal(1);
  end

  function automatic int pick(input logic [3:0] v);
    int k;
    for (int i = 0; i < N; i++) begin
      k = (rr_m + i) % N;
      if (v[k]) return k;
    end
    return 0;
  endfunction

  task automatic set_src(input int s, input logic [31:0] d, input logic [3:0] k, input logic [1:0] c);
    req_data[s*DW +: DW] = d;
    req_keep[s*BW +: BW] = k;
    req_cnt[s*CW +: CW] = c;
  endtask

  task automatic push_exp(input int s);
    hdr_t e;
    e.src = 2'(s);
    e.d = req_data[s*DW +: DW];
    e.k = req_keep[s*BW +: BW];
    e.c = req_cnt[s*CW +: CW];
    sb.push_back(e);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (|req_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic accept();
    ready_insert = 1'b1;
    @(negedge clk);
    ready_insert = 1'b0;
    hc_m++;
    #1;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      mon_valid_out = 1'b1;
      mon_ready_out = 1'b1;
      mon_last_out = (i == n - 1);
      @(negedge clk);
    end
    mon_valid_out = 1'b0;
    mon_ready_out = 1'b0;
    mon_last_out = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    ready_insert = 1'b0;
    err_clr = 1'b0;
    {mon_valid_out, mon_ready_out, mon_last_out} = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    rr_m = 0;
    hc_m = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({valid_insert, data_insert, keep_insert, byte_insert_cnt, req_ready, grant_id, busy, hdr_cnt, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h k=%b c=%0d rdy=%b g=%0d busy=%b hc=%0d err=%b, want all zero",
               valid_insert, data_insert, keep_insert, byte_insert_cnt, req_ready, grant_id, busy, hdr_cnt, err_timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b rdy=%b, want busy=0 rdy=0000", busy, req_ready);
    end
    rr_m = 0;
    hc_m = 0;
  endtask

  task automatic test_single();
    bit ok;
    set_src(2, 32'hA1B2C3D4, 4'b0011, 2'd2);
    req_valid = 4'b0100;
    wait_grant(ok);
    checks++;
    if (!ok || req_ready !== 4'(1 << pick(req_valid))) begin
      errors++;
      $display("FAIL single_ready: got %b, want %b", req_ready, 4'(1 << pick(req_valid)));
    end
    push_exp(pick(req_valid));
    @(negedge clk);
    req_valid = '0;
    #1;
    h = sb.pop_front();
    checks++;
    if ({valid_insert, grant_id, data_insert, keep_insert, byte_insert_cnt} !== {1'b1, h.src, h.d, h.k, h.c}) begin
      errors++;
      $display("FAIL single_hdr: got v=%b g=%0d d=%h k=%b c=%0d, want v=1 g=%0d d=%h k=%b c=%0d",
               valid_insert, grant_id, data_insert, keep_insert, byte_insert_cnt, h.src, h.d, h.k, h.c);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_ready_pulse: got %b, want 0000", req_ready);
    end
    accept();
    checks++;
    if (hdr_cnt !== 16'(hc_m) || busy !== 1'b1 || valid_insert !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got hc=%0d busy=%b v=%b, want hc=%0d busy=1 v=0", hdr_cnt, busy, valid_insert, hc_m);
    end
    beats(1);
    rr_m = (2 + 1) % N;
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd2 || dut.rr_ptr !== 2'(rr_m)) begin
      errors++;
      $display("FAIL single_done: got busy=%b g=%0d ptr=%0d, want busy=0 g=2 ptr=%0d", busy, grant_id, dut.rr_ptr, rr_m);
    end
  endtask

  task automatic test_skip();
    bit ok;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL skip_idle: got rdy=%b busy=%b, want rdy=0000 busy=0", req_ready, busy);
      end
    end
    set_src(0, 32'h0BAD_F00D, 4'b1000, 2'd1);
    req_valid = 4'b0001;
    wait_grant(ok);
    checks++;
    if (!ok || req_ready !== 4'(1 << pick(req_valid))) begin
      errors++;
      $display("FAIL skip_ready: got %b, want %b", req_ready, 4'(1 << pick(req_valid)));
    end
    push_exp(pick(req_valid));
    @(negedge clk);
    req_valid = '0;
    #1;
    h = sb.pop_front();
    checks++;
    if ({valid_insert, grant_id, data_insert, keep_insert, byte_insert_cnt} !== {1'b1, h.src, h.d, h.k, h.c}) begin
      errors++;
      $display("FAIL skip_hdr: got v=%b g=%0d d=%h, want v=1 g=%0d d=%h", valid_insert, grant_id, data_insert, h.src, h.d);
    end
    accept();
    beats(2);
    rr_m = 1;
  endtask

  task automatic test_contention();
    bit ok;
    int e;
    apply_reset();
    for (int s = 0; s < N; s++) set_src(s, 32'hC0DE_0000 + s, 4'(1 << s), 2'(s));
    req_valid = 4'hF;
    for (int p = 0; p < 5; p++) begin
      wait_grant(ok);
      e = pick(req_valid);
      checks++;
      if (!ok || req_ready !== 4'(1 << e)) begin
        errors++;
        $display("FAIL contention_ready[%0d]: got %b, want %b", p, req_ready, 4'(1 << e));
      end
      push_exp(e);
      @(negedge clk);
      #1;
      h = sb.pop_front();
      checks++;
      if ({valid_insert, grant_id, data_insert, keep_insert, byte_insert_cnt} !== {1'b1, h.src, h.d, h.k, h.c}) begin
        errors++;
        $display("FAIL contention_hdr[%0d]: got v=%b g=%0d d=%h, want v=1 g=%0d d=%h", p, valid_insert, grant_id, data_insert, h.src, h.d);
      end
      accept();
      for (int b = 0; b < 3; b++) begin
        mon_valid_out = 1'b1;
        mon_ready_out = 1'b1;
        mon_last_out = (b == 2);
        checks++;
        if (req_ready !== 4'b0000) begin
          errors++;
          $display("FAIL contention_hold[%0d]: got rdy=%b during packet, want 0000", p, req_ready);
        end
        @(negedge clk);
      end
      if (p == 4) req_valid = '0;
      {mon_valid_out, mon_ready_out, mon_last_out} = '0;
      rr_m = (e + 1) % N;
    end
    #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    set_src(2, 32'h5A5A_0F0F, 4'b1111, 2'd3);
    req_valid = 4'b0100;
    wait_grant(ok);
    checks++;
    if (!ok || req_ready !== 4'(1 << pick(req_valid))) begin
      errors++;
      $display("FAIL bp_ready: got %b, want %b", req_ready, 4'(1 << pick(req_valid)));
    end
    push_exp(pick(req_valid));
    @(negedge clk);
    req_valid = '0;
    set_src(2, 32'hDEAD_BEEF, 4'b0001, 2'd0);
    #1;
    h = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({valid_insert, grant_id, data_insert, keep_insert, byte_insert_cnt} !== {1'b1, h.src, h.d, h.k, h.c} || hdr_cnt !== 16'(hc_m)) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h k=%b c=%0d hc=%0d, want v=1 d=%h k=%b c=%0d hc=%0d",
                 i, valid_insert, data_insert, keep_insert, byte_insert_cnt, hdr_cnt, h.d, h.k, h.c, hc_m);
      end
      @(negedge clk);
      #1;
    end
    accept();
    checks++;
    if (hdr_cnt !== 16'(hc_m)) begin
      errors++;
      $display("FAIL bp_count: got %0d, want %0d", hdr_cnt, hc_m);
    end
    @(negedge clk);
    #1;
    checks++;
    if (hdr_cnt !== 16'(hc_m) || valid_insert !== 1'b0) begin
      errors++;
      $display("FAIL bp_count_once: got hc=%0d v=%b, want hc=%0d v=0", hdr_cnt, valid_insert, hc_m);
    end
    beats(1);
    rr_m = 3;
  endtask

  task automatic test_timeout();
    bit ok;
    set_src(0, 32'h1111_2222, 4'b0110, 2'd1);
    set_src(1, 32'h3333_4444, 4'b1100, 2'd2);
    req_valid = 4'b0011;
    wait_grant(ok);
    checks++;
    if (!ok || req_ready !== 4'(1 << pick(req_valid))) begin
      errors++;
      $display("FAIL to_ready: got %b, want %b", req_ready, 4'(1 << pick(req_valid)));
    end
    push_exp(pick(req_valid));
    @(negedge clk);
    #1;
    h = sb.pop_front();
    checks++;
    if ({valid_insert, grant_id, data_insert} !== {1'b1, h.src, h.d}) begin
      errors++;
      $display("FAIL to_hdr: got v=%b g=%0d d=%h, want v=1 g=%0d d=%h", valid_insert, grant_id, data_insert, h.src, h.d);
    end
    accept();
    repeat (7) @(negedge clk);
    #1;
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: got err=%b busy=%b after 7 idle cycles, want err=0 busy=1", err_timeout, busy);
    end
    @(negedge clk);
    #1;
    rr_m = 1;
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || req_ready !== 4'(1 << pick(req_valid))) begin
      errors++;
      $display("FAIL to_fire: got err=%b busy=%b rdy=%b, want err=1 busy=0 rdy=%b", err_timeout, busy, req_ready, 4'(1 << pick(req_valid)));
    end
    push_exp(pick(req_valid));
    @(negedge clk);
    req_valid = '0;
    err_clr = 1'b1;
    #1;
    h = sb.pop_front();
    checks++;
    if ({valid_insert, grant_id, data_insert, keep_insert, byte_insert_cnt, err_timeout} !== {1'b1, h.src, h.d, h.k, h.c, 1'b1}) begin
      errors++;
      $display("FAIL to_next_grant: got v=%b g=%0d d=%h err=%b, want v=1 g=%0d d=%h err=1", valid_insert, grant_id, data_insert, err_timeout, h.src, h.d);
    end
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: got err=%b, want 0", err_timeout);
    end
    accept();
    beats(1);
    rr_m = 2;
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_src(2, 32'h7777_8888, 4'b0101, 2'd3);
    req_valid = 4'b0100;
    wait_grant(ok);
    @(negedge clk);
    req_valid = '0;
    #1;
    accept();
    mon_valid_out = 1'b1;
    mon_ready_out = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_insert, data_insert, keep_insert, byte_insert_cnt, req_ready, grant_id, busy, hdr_cnt, err_timeout} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got v=%b d=%h k=%b c=%0d rdy=%b g=%0d busy=%b hc=%0d, want all zero",
               valid_insert, data_insert, keep_insert, byte_insert_cnt, req_ready, grant_id, busy, hdr_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    {mon_valid_out, mon_ready_out} = '0;
    rr_m = 0;
    hc_m = 0;
    set_src(1, 32'h9999_AAAA, 4'b0111, 2'd1);
    req_valid = 4'b0010;
    wait_grant(ok);
    checks++;
    if (!ok || req_ready !== 4'(1 << pick(req_valid))) begin
      errors++;
      $display("FAIL rst_regrant: got %b, want %b", req_ready, 4'(1 << pick(req_valid)));
    end
    push_exp(pick(req_valid));
    @(negedge clk);
    req_valid = '0;
    #1;
    h = sb.pop_front();
    checks++;
    if ({valid_insert, grant_id, data_insert, keep_insert, byte_insert_cnt} !== {1'b1, h.src, h.d, h.k, h.c}) begin
      errors++;
      $display("FAIL rst_hdr: got v=%b g=%0d d=%h, want v=1 g=%0d d=%h", valid_insert, grant_id, data_insert, h.src, h.d);
    end
    accept();
    checks++;
    if (hdr_cnt !== 16'(hc_m)) begin
      errors++;
      $display("FAIL rst_count: got %0d, want %0d", hdr_cnt, hc_m);
    end
    beats(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_skip();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_header_arbiter.md
Name: axis_header_arbiter

Overview:
- Round-robin scheduler that shares one axi_stream_insert_header instance among NUM_SRC header requesters.
- Captures one requester's header and offers it on the inserter's insert port (valid_insert/ready_insert).
- Holds the grant until the inserted packet's final output beat is handshaken (valid_out && ready_out && last_out), then re-arbitrates.
- A watchdog releases the grant if the output stream stalls.

Parameters:
- DATA_WD, 32, header/stream data width in bits.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the byte count.
- NUM_SRC, 4, number of header requesters (2..16).
- SRC_WD, $clog2(NUM_SRC), grant index width.
- TIMEOUT_CYC, 1024, idle output cycles in WAIT_PKT before the watchdog fires (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_SRC  per-source header valid.
- req_data  in  NUM_SRC*DATA_WD  per-source header; source k occupies [k*DATA_WD +: DATA_WD].
- req_keep  in  NUM_SRC*DATA_BYTE_WD  per-source header keep, packed the same way.
- req_cnt  in  NUM_SRC*BYTE_CNT_WD  per-source byte_insert_cnt, packed the same way.
- req_ready  out  NUM_SRC  one-hot capture acknowledge.
- valid_insert  out  1  to inserter.
- data_insert  out  DATA_WD  to inserter.
- keep_insert  out  DATA_BYTE_WD  to inserter.
- byte_insert_cnt  out  BYTE_CNT_WD  to inserter.
- ready_insert  in  1  from inserter.
- mon_valid_out  in  1  inserter valid_out (monitor only).
- mon_ready_out  in  1  downstream ready_out (monitor only).
- mon_last_out  in  1  inserter last_out (monitor only).
- grant_id  out  SRC_WD  current/last granted source.
- busy  out  1  high in OFFER or WAIT_PKT.
- hdr_cnt  out  16  headers accepted by the inserter; wraps.
- err_timeout  out  1  sticky watchdog flag.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset values:
  - state=IDLE; valid_insert=0; data/keep/byte_insert_cnt=0; req_ready=0.
  - grant_id=0; rr_ptr=0; busy=0; hdr_cnt=0; err_timeout=0; watchdog=0.
- IDLE:
  - Combinational round-robin search starts at rr_ptr and picks the first k with req_valid[k].
  - req_ready[k]=1 that cycle; it is combinational and only in IDLE, so it is one cycle wide.
  - On that edge, register req_data/keep/cnt of k into the data_insert/keep_insert/byte_insert_cnt regs, set grant_id=k, go to OFFER.
  - If no request, stay in IDLE with all req_ready=0.
- OFFER:
  - valid_insert=1; outputs held stable until ready_insert.
  - On valid_insert && ready_insert: hdr_cnt+1, watchdog cleared, go to WAIT_PKT.
  - Header latency: grant cycle to valid_insert = 1 cycle.
- WAIT_PKT:
  - valid_insert=0.
  - Beat = mon_valid_out && mon_ready_out. Watchdog clears on each beat and increments otherwise.
  - Beat with mon_last_out: rr_ptr=(grant_id+1) mod NUM_SRC, go to IDLE. Next grant can be issued the following cycle.
  - Watchdog reaching TIMEOUT_CYC-1 with no beat: err_timeout=1, rr_ptr advanced as above, go to IDLE.
  - A beat in that same cycle wins over the timeout.
- Monitor inputs are ignored in IDLE and OFFER.
- rr_ptr changes only on packet end or timeout, so a source re-asserting req_valid cannot starve others.
- err_timeout:
  - Set has priority over err_clr in the same cycle.
  - err_clr in any other cycle clears it.
- req_valid dropping while its source waits is legal; it is simply not selected.
- Once captured, the header is owned by the arbiter.
- NUM_SRC not a power of two: the pointer wraps explicitly at NUM_SRC-1.
- Asynchronous reset mid-packet returns everything to reset values immediately. No header is replayed.

Decomposition:
- Shared package: state enum (IDLE, OFFER, WAIT_PKT), HDR_CNT_WD=16.
- One sub-module: rr_arbiter. It takes req, ptr and en, and outputs a one-hot grant plus index; it is purely combinational.
- Watchdog and counters stay in the top level.

Test Plan:
- Single source, NUM_SRC=4: req_valid=4'b0100, data 32'hA1B2C3D4, keep 4'b0011, cnt 2.
  - req_ready[2] pulses one cycle; next cycle valid_insert=1 with the same values.
  - After ready_insert: hdr_cnt=1, busy=1.
  - After the beat with last: grant_id=2, rr_ptr=3, busy=0.
- Contention: req_valid=4'b1111 held, each packet 3 beats.
  - Grant order is 0,1,2,3,0.
  - No second req_ready occurs before the previous packet's last beat.
- Backpressure: ready_insert low for 5 cycles in OFFER.
  - valid_insert and header stay stable for 5 cycles; hdr_cnt increments exactly once.
- Timeout, TIMEOUT_CYC=8: no mon beats after insert acceptance.
  - err_timeout=1 after 8 cycles, state IDLE, the next source is granted.
  - err_clr pulse clears err_timeout.
- Reset mid-WAIT_PKT: rst_n low for 1 cycle.
  - All outputs return to reset values; req_valid=4'b0010 then gets grant 1 first.
- Skip logic: rr_ptr=3, req_valid=4'b0001 -> grant 0. With req_valid=0, req_ready stays 0 and busy stays 0.
